fir_result_tx: RTL and testbench

//  Transmit side of the FIR engine's external byte port. Buffers filtered results from the FIR

---
 rtl/fir_result_tx_pkg.sv | 19 +
 rtl/fir_result_tx_if.sv | 29 ++
 rtl/fir_result_tx_fifo.sv | 53 +++++
 rtl/fir_result_tx.sv | 123 ++++++++++++
 tb/tb_fir_result_tx.sv | 343 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fir_result_tx_pkg.sv
// Shared definitions for the FIR result transmit path.
//  BYTE_W           width of one host-port byte
//  RESULT_WIDTH_DEF default width of a signed FIR result
//  nbytes()         number of bytes needed to carry a result of a given width
//  StIdle/StSend/StRelease  transmit FSM state encoding
package fir_result_tx_pkg;

  localparam int unsigned BYTE_W           = 8;
  localparam int unsigned RESULT_WIDTH_DEF = 24;

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StSend    = 2'd1;
  localparam logic [1:0] StRelease = 2'd2;

  function automatic int unsigned nbytes(input int unsigned width);
    return (width + BYTE_W - 1) / BYTE_W;
  endfunction

endpackage

// File: rtl/fir_result_tx_if.sv
// Result input and host byte-port signals of fir_result_tx.
//  result_valid/result_data/result_ready  push side from the FIR datapath
//  tx_data/tx_strobe/tx_first/host_ack    4-phase strobe/ack byte port to the host
//  overflow                               sticky push-while-full flag
// master: the transmitter; slave: datapath plus host.
interface fir_result_tx_if
  import fir_result_tx_pkg::*;
#(
  parameter int unsigned RESULT_WIDTH = RESULT_WIDTH_DEF
);
  logic                    result_valid;
  logic [RESULT_WIDTH-1:0] result_data;
  logic                    result_ready;
  logic [BYTE_W-1:0]       tx_data;
  logic                    tx_strobe;
  logic                    tx_first;
  logic                    host_ack;
  logic                    overflow;

  modport master (
    input  result_valid, result_data, host_ack,
    output result_ready, tx_data, tx_strobe, tx_first, overflow
  );

  modport slave (
    output result_valid, result_data, host_ack,
    input  result_ready, tx_data, tx_strobe, tx_first, overflow
  );
endinterface

// File: rtl/fir_result_tx_fifo.sv
// Synchronous FIFO buffering FIR results ahead of the byte transmitter.
//  clk, rst_n     clock, asynchronous active-low reset
//  push, wdata    write request / data (ignored when full)
//  pop, rdata     read request (ignored when empty) / head-of-queue data
//  full, empty    occupancy flags
//  count          occupancy, 0..DEPTH
module fir_result_fifo #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             push_ok, pop_ok;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = count_q;

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_ok && !pop_ok)      count_q <= count_q + 1'b1;
      else if (pop_ok && !push_ok) count_q <= count_q - 1'b1;
    end
  end

endmodule

// File: rtl/fir_result_tx.sv
// Transmit side of the FIR engine byte port: buffers results and sends each one
// sign-extended, MSB byte first, over a 4-phase strobe/ack handshake.
//  clk, rst_n  clock, asynchronous active-low reset
//  ena         design enable; low freezes FSM and FIFO
//  bus         result push side and host byte port (see fir_result_tx_if)
module fir_result_tx
  import fir_result_tx_pkg::*;
#(
  parameter int unsigned RESULT_WIDTH = RESULT_WIDTH_DEF,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  fir_result_tx_if.master   bus
);
  localparam int unsigned NBYTES = nbytes(RESULT_WIDTH);
  localparam int unsigned TX_W   = NBYTES * BYTE_W;
  localparam int unsigned CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int unsigned FAW    = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NBYTES - 1);
  localparam logic [FAW:0]     FULL_CNT = (FAW+1)'(FIFO_DEPTH);

  logic [RESULT_WIDTH-1:0] fifo_rdata;
  logic                    fifo_full, fifo_empty, push, pop;
  logic [FAW:0]            fifo_count;
  logic [TX_W-1:0]         ext;

  logic                    live_q;       // low only until the first clock after reset
  logic                    ack_meta_q, ack_s_q;
  logic                    ovf_q;
  logic [1:0]              state_q, state_d;
  logic [TX_W-1:0]         shift_q, shift_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    first_q, first_d;

  // Readiness comes from the registered (pre-pop) count, so a push in the same
  // cycle a full FIFO pops is refused and flagged as overflow.
  assign bus.result_ready = live_q & ena & (fifo_count != FULL_CNT);
  assign push             = bus.result_valid & bus.result_ready;
  assign ext              = TX_W'(signed'(fifo_rdata));

  assign bus.tx_data   = shift_q[TX_W-1 -: BYTE_W];
  assign bus.tx_strobe = (state_q == StSend);
  assign bus.tx_first  = first_q;
  assign bus.overflow  = ovf_q;

  fir_result_fifo #(
    .WIDTH (RESULT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (bus.result_data),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    first_d = first_q;
    pop     = 1'b0;
    if (ena) begin
      case (state_q)
        StIdle: begin
          // A stale ack from the host must clear before a new byte is offered.
          if (!fifo_empty && !ack_s_q) begin
            pop     = 1'b1;
            shift_d = ext;
            cnt_d   = '0;
            first_d = 1'b1;
            state_d = StSend;
          end
        end
        StSend: begin
          if (ack_s_q) state_d = StRelease;
        end
        StRelease: begin
          if (!ack_s_q) begin
            if (cnt_q == CNT_LAST) begin
              state_d = StIdle;
            end else begin
              shift_d = shift_q << BYTE_W;
              cnt_d   = cnt_q + 1'b1;
              first_d = 1'b0;
              state_d = StSend;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live_q     <= 1'b0;
      ack_meta_q <= 1'b0;
      ack_s_q    <= 1'b0;
      ovf_q      <= 1'b0;
      state_q    <= StIdle;
      shift_q    <= '0;
      cnt_q      <= '0;
      first_q    <= 1'b0;
    end else begin
      live_q     <= 1'b1;
      ack_meta_q <= bus.host_ack;
      ack_s_q    <= ack_meta_q;
      if (ena && live_q && bus.result_valid && fifo_full) ovf_q <= 1'b1;
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      first_q    <= first_d;
    end
  end

endmodule

// File: tb/tb_fir_result_tx.sv
module tb_fir_result_tx;

  logic clk = 1'b0;
  logic rst_n;
  logic ena;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fir_result_tx_if #(.RESULT_WIDTH(24)) bus24 ();
  fir_result_tx_if #(.RESULT_WIDTH(20)) bus20 ();

  fir_result_tx #(.RESULT_WIDTH(24), .FIFO_DEPTH(4)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .bus   (bus24)
  );

  fir_result_tx #(.RESULT_WIDTH(20), .FIFO_DEPTH(4)) u_dut20 (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .bus   (bus20)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut(input logic ack_level);
    rst_n = 1'b0;
    bus24.result_valid = 1'b0;
    bus20.result_valid = 1'b0;
    bus24.host_ack = ack_level;
    bus20.host_ack = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
  endtask

  // Expected byte i (0 = most significant) of a result, sign-extended to nb bytes.
  function automatic logic [7:0] exp_byte(input int unsigned v, input int w, input int i);
    int sv;
    int nb;
    nb = (w + 7) / 8;
    sv = int'(v);
    if (w < 32 && ((v >> (w - 1)) & 1) == 1) sv = sv - (1 << w);
    return 8'((sv >>> (8 * (nb - 1 - i))) & 255);
  endfunction

  task automatic push24(input logic [23:0] v);
    int n = 0;
    bus24.result_valid = 1'b1;
    bus24.result_data  = v;
    while (bus24.result_ready !== 1'b1 && n < 50) begin step(); n++; end
    checks++;
    if (n >= 50) begin
      errors++;
      $display("FAIL push24_ready_timeout got %0b want 1", bus24.result_ready);
    end
    step();
    bus24.result_valid = 1'b0;
  endtask

  // One host byte transfer on bus24: wait strobe, check, ack, wait release, unack.
  task automatic recv_byte(input logic [7:0] exp_d, input logic exp_f, input int gap);
    int n = 0;
    logic [7:0] held;
    logic moved = 1'b0;
    while (bus24.tx_strobe !== 1'b1 && n < 60) begin step(); n++; end
    checks++;
    if (bus24.tx_strobe !== 1'b1) begin
      errors++;
      $display("FAIL strobe_timeout got %0b want 1", bus24.tx_strobe);
      return;
    end
    checks++;
    if (bus24.tx_data !== exp_d) begin
      errors++;
      $display("FAIL tx_data got %02h want %02h", bus24.tx_data, exp_d);
    end
    checks++;
    if (bus24.tx_first !== exp_f) begin
      errors++;
      $display("FAIL tx_first got %0b want %0b", bus24.tx_first, exp_f);
    end
    held = bus24.tx_data;
    repeat (gap) begin
      step();
      if (bus24.tx_data !== held || bus24.tx_strobe !== 1'b1) moved = 1'b1;
    end
    bus24.host_ack = 1'b1;
    n = 0;
    while (bus24.tx_strobe === 1'b1 && n < 60) begin
      step();
      n++;
      if (bus24.tx_data !== held) moved = 1'b1;
    end
    checks++;
    if (bus24.tx_strobe !== 1'b0) begin
      errors++;
      $display("FAIL release_timeout got %0b want 0", bus24.tx_strobe);
    end
    checks++;
    if (moved !== 1'b0 || bus24.tx_data !== held) begin
      errors++;
      $display("FAIL data_stable got %02h want %02h", bus24.tx_data, held);
    end
    bus24.host_ack = 1'b0;
    step();
  endtask

  task automatic recv24(input logic [23:0] v);
    for (int i = 0; i < 3; i++)
      recv_byte(exp_byte(32'(v), 24, i), (i == 0), int'($urandom_range(0, 3)));
  endtask

  task automatic expect_quiet24(input int cycles, input string name);
    logic seen = 1'b0;
    repeat (cycles) begin
      step();
      if (bus24.tx_strobe !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL %s got strobe 1 want 0", name);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++;
    if ({bus24.tx_strobe, bus24.tx_first, bus24.result_ready, bus24.overflow} !== 4'b0 ||
        bus24.tx_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs got s%0b f%0b r%0b o%0b d%02h want all 0",
               bus24.tx_strobe, bus24.tx_first, bus24.result_ready, bus24.overflow,
               bus24.tx_data);
    end
    repeat (2) step();
    rst_n = 1'b1;
    step();
    checks++;
    if (bus24.result_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset got %0b want 1", bus24.result_ready);
    end
  endtask

  task automatic test_single();
    push24(24'h123456);
    checks++;
    if (bus24.tx_strobe !== 1'b0) begin
      errors++;
      $display("FAIL latency got strobe %0b want 0", bus24.tx_strobe);
    end
    recv24(24'h123456);
    expect_quiet24(10, "idle_after_single");
  endtask

  task automatic test_width20();
    logic [19:0] vals [3];
    vals[0] = 20'h80001;
    vals[1] = 20'(($urandom() & 32'h7ffff));
    vals[2] = 20'(($urandom() | 32'h80000));
    for (int k = 0; k < 3; k++) begin
      int n = 0;
      bus20.result_valid = 1'b1;
      bus20.result_data  = vals[k];
      while (bus20.result_ready !== 1'b1 && n < 50) begin step(); n++; end
      step();
      bus20.result_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
        logic [7:0] want;
        want = exp_byte(32'(vals[k]), 20, i);
        n = 0;
        while (bus20.tx_strobe !== 1'b1 && n < 60) begin step(); n++; end
        checks++;
        if (bus20.tx_data !== want || bus20.tx_first !== (i == 0)) begin
          errors++;
          $display("FAIL w20_byte got %02h/%0b want %02h/%0b", bus20.tx_data,
                   bus20.tx_first, want, (i == 0));
        end
        bus20.host_ack = 1'b1;
        n = 0;
        while (bus20.tx_strobe === 1'b1 && n < 60) begin step(); n++; end
        bus20.host_ack = 1'b0;
        step();
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [23:0] q[$];
    for (int r = 0; r < 4; r++) begin
      int k;
      k = int'($urandom_range(1, 5));
      for (int j = 0; j < k; j++) begin
        logic [23:0] v;
        v = 24'($urandom());
        q.push_back(v);
        push24(v);
      end
      while (q.size() > 0) recv24(q.pop_front());
    end
    expect_quiet24(8, "idle_after_random");
  endtask

  task automatic test_overflow();
    logic [23:0] q[$];
    reset_dut(1'b0);
    for (int j = 0; j < 5; j++) begin
      logic [23:0] v;
      v = 24'($urandom());
      q.push_back(v);
      push24(v);
    end
    checks++;
    if (bus24.result_ready !== 1'b0 || bus24.overflow !== 1'b0) begin
      errors++;
      $display("FAIL full_state got r%0b o%0b want r0 o0", bus24.result_ready, bus24.overflow);
    end
    bus24.result_valid = 1'b1;
    bus24.result_data  = 24'hdeadbe;
    repeat (3) step();
    bus24.result_valid = 1'b0;
    checks++;
    if (bus24.overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_set got %0b want 1", bus24.overflow);
    end
    while (q.size() > 0) recv24(q.pop_front());
    expect_quiet24(10, "overflow_dropped");
    checks++;
    if (bus24.overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_sticky got %0b want 1", bus24.overflow);
    end
  endtask

  task automatic test_ena_hold();
    logic [23:0] v;
    logic [7:0]  held;
    logic        bad = 1'b0;
    int          n = 0;
    reset_dut(1'b0);
    v = 24'($urandom());
    push24(v);
    while (bus24.tx_strobe !== 1'b1 && n < 60) begin step(); n++; end
    checks++;
    if (bus24.tx_data !== exp_byte(32'(v), 24, 0)) begin
      errors++;
      $display("FAIL ena_first_byte got %02h want %02h", bus24.tx_data, exp_byte(32'(v), 24, 0));
    end
    held = bus24.tx_data;
    ena = 1'b0;
    bus24.host_ack = 1'b1;
    repeat (8) begin
      step();
      if (bus24.tx_strobe !== 1'b1 || bus24.tx_data !== held) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0) begin
      errors++;
      $display("FAIL ena_hold got s%0b d%02h want s1 d%02h", bus24.tx_strobe, bus24.tx_data, held);
    end
    checks++;
    if (bus24.result_ready !== 1'b0) begin
      errors++;
      $display("FAIL ena_ready got %0b want 0", bus24.result_ready);
    end
    ena = 1'b1;
    n = 0;
    while (bus24.tx_strobe === 1'b1 && n < 60) begin step(); n++; end
    bus24.host_ack = 1'b0;
    step();
    recv_byte(exp_byte(32'(v), 24, 1), 1'b0, 1);
    recv_byte(exp_byte(32'(v), 24, 2), 1'b0, 0);
    expect_quiet24(8, "ena_no_extra");
  endtask

  task automatic test_reset_mid();
    logic [23:0] v;
    int n = 0;
    reset_dut(1'b0);
    v = 24'($urandom());
    push24(v);
    recv_byte(exp_byte(32'(v), 24, 0), 1'b1, 0);
    while (bus24.tx_strobe !== 1'b1 && n < 60) begin step(); n++; end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus24.tx_strobe, bus24.tx_first, bus24.result_ready} !== 3'b0 ||
        bus24.tx_data !== 8'h00) begin
      errors++;
      $display("FAIL async_reset got s%0b f%0b r%0b d%02h want all 0", bus24.tx_strobe,
               bus24.tx_first, bus24.result_ready, bus24.tx_data);
    end
    step();
    rst_n = 1'b1;
    step();
    v = 24'($urandom());
    push24(v);
    recv24(v);
  endtask

  task automatic test_ack_high();
    logic [23:0] v;
    reset_dut(1'b1);
    v = 24'($urandom());
    push24(v);
    expect_quiet24(10, "ack_high_blocks");
    bus24.host_ack = 1'b0;
    recv24(v);
  endtask

  initial begin
    ena = 1'b1;
    rst_n = 1'b1;
    bus24.result_valid = 1'b0;
    bus24.result_data  = '0;
    bus24.host_ack     = 1'b0;
    bus20.result_valid = 1'b0;
    bus20.result_data  = '0;
    bus20.host_ack     = 1'b0;
    test_reset();
    test_single();
    test_width20();
    test_back_to_back();
    test_overflow();
    test_ena_hold();
    test_reset_mid();
    test_ack_high();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
